// File: rtl/mvm_result_serializer_if.sv
// Valid/ready bundle from the MVM lane results to the activation buffer.
interface mvm_result_serializer_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_results;
    logic         relu_en;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic [1:0]   out_lane;
    logic         out_last;

    modport master (
        output in_valid,
        output in_results,
        output relu_en,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_lane,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_results,
        input  relu_en,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_lane,
        output out_last
    );
endinterface

// File: rtl/mvm_result_serializer.sv
// Requantizes four 32-bit MVM lane results to int16 and streams them
// lane 0..3 over valid/ready, counting saturated lanes.
module mvm_result_serializer #(
    parameter int SHIFT = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    mvm_result_serializer_if.slave bus,
    input  logic                 sat_clr,
    output logic [CNT_W-1:0]     sat_count
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [32:0] RND = (33'd1 << SHIFT) >> 1;

    state_t             state;
    state_t             state_nxt;
    logic [15:0]        lane_buf [4];
    logic [1:0]         lane;
    logic               cap;
    logic               hs;
    logic               last_hs;
    logic signed [32:0] ext [4];
    logic signed [32:0] shf [4];
    logic [15:0]        q_word [4];
    logic [3:0]         q_sat;
    logic [2:0]         sat_sum;
    logic [CNT_W:0]     sat_wide;
    logic [CNT_W-1:0]   sat_add;

    // Rounding offset is added in 33 bits so 0x7FFFFFFF cannot wrap.
    always_comb begin
        q_sat = '0;
        for (int i = 0; i < 4; i++) begin
            ext[i] = $signed({bus.in_results[32*i+31],
                              bus.in_results[32*i +: 32]} + RND);
            shf[i] = ext[i] >>> SHIFT;
            if (shf[i] > 33'sd32767) begin
                q_word[i] = 16'h7fff;
                q_sat[i]  = 1'b1;
            end else if (shf[i] < -33'sd32768) begin
                q_word[i] = 16'h8000;
                q_sat[i]  = 1'b1;
            end else begin
                q_word[i] = shf[i][15:0];
            end
            if (bus.relu_en && q_word[i][15])
                q_word[i] = '0;
        end
    end

    always_comb begin
        sat_sum  = 3'(q_sat[0]) + 3'(q_sat[1])
                 + 3'(q_sat[2]) + 3'(q_sat[3]);
        sat_wide = {1'b0, sat_count} + (CNT_W+1)'(sat_sum);
        sat_add  = sat_wide[CNT_W] ? '1 : sat_wide[CNT_W-1:0];
    end

    assign hs      = bus.out_valid && bus.out_ready;
    assign last_hs = hs && (lane == 2'd3);
    assign cap     = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (cap) state_nxt = SEND;
            SEND: if (last_hs && !cap) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid = (state == SEND);
        bus.in_ready  = (state == IDLE) || last_hs;
        bus.out_lane  = lane;
        bus.out_data  = lane_buf[lane];
        bus.out_last  = bus.out_valid && (lane == 2'd3);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane <= '0;
            for (int i = 0; i < 4; i++)
                lane_buf[i] <= '0;
        end else if (cap) begin
            lane <= '0;
            for (int i = 0; i < 4; i++)
                lane_buf[i] <= q_word[i];
        end else if (hs) begin
            lane <= lane + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sat_count <= '0;
        else if (sat_clr)
            sat_count <= '0;
        else if (cap)
            sat_count <= sat_add;
    end

endmodule

// File: tb/tb_mvm_result_serializer.sv
// Directed and randomized checks of mvm_result_serializer against
// a queue-based reference model.
module tb_mvm_result_serializer;

    localparam int SH = 8;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  lane;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sat_clr = 1'b0;
    logic [15:0] sat_count;

    int          n_tests = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    bit          rnd_ready = 1'b0;
    word_t       exp_q [$];
    logic [15:0] got_q [$];
    int          m_cnt = 0;
    int          base;

    mvm_result_serializer_if bus ();

    mvm_result_serializer #(.SHIFT(SH), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .sat_clr   (sat_clr),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {saturated, word}; floor division gives the arithmetic shift.
    function automatic logic [16:0] quant(input logic [31:0] x, input bit relu);
        longint v = longint'($signed(x));
        longint d = longint'(1) << SH;
        bit     s = 1'b0;
        v = v + d / 2;
        v = (v >= 0) ? v / d : -((-v + d - 1) / d);
        if (v > 32767) begin
            v = 32767;
            s = 1'b1;
        end else if (v < -32768) begin
            v = -32768;
            s = 1'b1;
        end
        if (relu && v < 0)
            v = 0;
        return {s, v[15:0]};
    endfunction

    always @(negedge clk) begin
        word_t       w;
        logic [16:0] r;
        int          nsat;
        bit          cap;
        if (mon_en) begin
            cap  = bus.in_valid && bus.in_ready;
            nsat = 0;
            check("in_ready", bus.in_ready,
                  (exp_q.size() == 0) || (bus.out_ready && exp_q.size() == 1));
            check("out_valid", bus.out_valid, exp_q.size() != 0);
            check("sat_count", sat_count, m_cnt);
            if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("out_data", bus.out_data, w.data);
                check("out_lane", bus.out_lane, w.lane);
                check("out_last", bus.out_last, w.last);
                got_q.push_back(bus.out_data);
            end
            if (cap) begin
                for (int i = 0; i < 4; i++) begin
                    r = quant(bus.in_results[32*i +: 32], bus.relu_en);
                    exp_q.push_back('{r[15:0], 2'(i), i == 3});
                    nsat += int'(r[16]);
                end
            end
            if (sat_clr)
                m_cnt = 0;
            else if (cap)
                m_cnt = (m_cnt + nsat > 65535) ? 65535 : m_cnt + nsat;
        end
    end

    always @(posedge clk) begin
        if (rnd_ready) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [127:0] v, input bit relu, input bit clr);
        int n = 0;
        bit acc;
        bus.in_valid   = 1'b1;
        bus.in_results = v;
        bus.relu_en    = relu;
        sat_clr        = clr;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 50);
        if (!acc)
            check("send_timeout", 0, 1);
        sat_clr = 1'b0;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic check_words(input string tag, input int b,
                               input logic [15:0] e [4]);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s%0d", tag, i), got_q[b+i], e[i]);
    endtask

    localparam logic [127:0] V_BASIC =
        {32'hfffffc18, 32'd384, 32'd383, 32'h00001234};
    localparam logic [127:0] V_SAT =
        {32'd0, 32'd0, 32'h80000000, 32'h7fffffff};
    localparam logic [127:0] V_RELU =
        {32'hffffffff, 32'd256, 32'h80000000, 32'hfffffc18};

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_results = '0;
        bus.relu_en    = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_lane", bus.out_lane, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_sat_count", sat_count, 0);
        reset = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        mon_en = 1'b1;

        base = got_q.size();
        send(V_BASIC, 1'b0, 1'b0);
        idle();
        drain();
        check_words("basic", base, '{16'd18, 16'd1, 16'd2, 16'hfffc});

        base = got_q.size();
        send(V_SAT, 1'b0, 1'b0);
        idle();
        drain();
        check_words("sat", base, '{16'h7fff, 16'h8000, 16'd0, 16'd0});
        check("sat_cnt2", sat_count, 2);
        send(V_SAT, 1'b0, 1'b1);
        idle();
        drain();
        check("sat_clr", sat_count, 0);

        base = got_q.size();
        send(V_RELU, 1'b1, 1'b0);
        idle();
        drain();
        check_words("relu", base, '{16'd0, 16'd0, 16'd1, 16'd0});
        check("relu_cnt", sat_count, 1);

        base = got_q.size();
        send(V_BASIC, 1'b0, 1'b0);
        idle();
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_lane", bus.out_lane, 1);
            check("bp_data", bus.out_data, 1);
            check("bp_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();
        check_words("bp", base, '{16'd18, 16'd1, 16'd2, 16'hfffc});

        base = got_q.size();
        send(V_BASIC, 1'b0, 1'b0);
        send(V_RELU, 1'b1, 1'b0);
        idle();
        drain();
        check_words("b2b_a", base, '{16'd18, 16'd1, 16'd2, 16'hfffc});
        check_words("b2b_b", base + 4, '{16'd0, 16'd0, 16'd1, 16'd0});

        send(V_SAT, 1'b0, 1'b0);
        idle();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_sat", sat_count, 0);
        check("mid_rst_lane", bus.out_lane, 0);
        exp_q.delete();
        m_cnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("post_rst_ready", bus.in_ready, 1);
        mon_en = 1'b1;
        base = got_q.size();
        send(V_BASIC, 1'b0, 1'b0);
        idle();
        drain();
        check_words("post_rst", base, '{16'd18, 16'd1, 16'd2, 16'hfffc});

        rnd_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [127:0] v;
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 2))
                    0: v[32*i +: 32] = $urandom();
                    1: v[32*i +: 32] = $urandom_range(0, 8388607);
                    default: v[32*i +: 32] = -$urandom_range(0, 8388607);
                endcase
            end
            send(v, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) begin
                idle();
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        idle();
        rnd_ready = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
